stage1_imm_ctrl: RTL and testbench

STAGE1_IMM_CTRL -- requirements
Module: stage1_imm_ctrl

---
 rtl/stage1_imm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stage1_imm_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stage1_imm_ctrl.sv
// ----------------------------------------------------------------------------
// stage1_imm_ctrl
//
// Two-entry instruction buffer sitting in front of the immediate generator.
// Each instruction is decoded into an immediate type (plus an illegal flag) as
// it is pushed, and the decoded bits are stored beside the instruction.  The
// head entry therefore presents registered type/illegal bits with no
// combinational path from in_inst.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   in_inst      : instruction from fetch
//   in_valid     : in_inst is valid
//   in_ready     : buffer accepts in_inst this cycle (state is not FULL)
//   flush        : synchronous kill of every buffered entry
//   out_inst     : head instruction (0 when empty)
//   out_imm_type : head immediate type (R when empty)
//   out_illegal  : head opcode unrecognised (0 when empty)
//   out_valid    : head entry is valid
//   out_ready    : downstream consumes the head this cycle
//   illegal_cnt  : saturating count of accepted illegal instructions
//
// Immediate type encodings (shared with the immediate generator):
//   R=0, I=1, ISTAR=2, S=3, B=4, U=5, J=6
// ----------------------------------------------------------------------------
module stage1_imm_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_inst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] out_inst,
    output logic [2:0]  out_imm_type,
    output logic        out_illegal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] illegal_cnt
);

    localparam logic [2:0] IMM_R     = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_ISTAR = 3'd2;
    localparam logic [2:0] IMM_S     = 3'd3;
    localparam logic [2:0] IMM_B     = 3'd4;
    localparam logic [2:0] IMM_U     = 3'd5;
    localparam logic [2:0] IMM_J     = 3'd6;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // Returns {illegal, imm_type}
    function automatic logic [3:0] decode(input logic [6:0] opcode,
                                          input logic [2:0] funct3);
        logic [3:0] res;
        case (opcode)
            7'b0110011: res = {1'b0, IMM_R};
            7'b0000011,
            7'b1100111,
            7'b1110011: res = {1'b0, IMM_I};
            // Shift-immediates carry a shamt field, hence the distinct type
            7'b0010011: res = (funct3 == 3'b001 || funct3 == 3'b101) ?
                              {1'b0, IMM_ISTAR} : {1'b0, IMM_I};
            7'b0100011: res = {1'b0, IMM_S};
            7'b1100011: res = {1'b0, IMM_B};
            7'b0110111,
            7'b0010111: res = {1'b0, IMM_U};
            7'b1101111: res = {1'b0, IMM_J};
            default:    res = {1'b1, IMM_R};
        endcase
        return res;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] inst_q [DEPTH];
    logic [31:0] inst_d [DEPTH];
    logic [2:0]  type_q [DEPTH];
    logic [2:0]  type_d [DEPTH];
    logic        ill_q  [DEPTH];
    logic        ill_d  [DEPTH];
    logic [15:0] cnt_q, cnt_d;

    logic       push;
    logic       pop;
    logic       wr_idx;
    logic [2:0] dec_type;
    logic       dec_illegal;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {dec_illegal, dec_type} = decode(in_inst[6:0], in_inst[14:12]);

    // Entry 0 is always the head.  A push lands behind whatever survives the
    // same-cycle pop: slot 1 only when one entry stays resident.
    assign wr_idx = (state_q == ST_ONE) && !pop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push)         state_d = ST_ONE;
            ST_ONE:   if (push && !pop) state_d = ST_FULL;
                      else if (!push && pop) state_d = ST_EMPTY;
            ST_FULL:  if (pop)          state_d = ST_ONE;
            default:                    state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            inst_d[i] = inst_q[i];
            type_d[i] = type_q[i];
            ill_d[i]  = ill_q[i];
        end
        if (pop) begin
            inst_d[0] = inst_q[1];
            type_d[0] = type_q[1];
            ill_d[0]  = ill_q[1];
        end
        if (push) begin
            inst_d[wr_idx] = in_inst;
            type_d[wr_idx] = dec_type;
            ill_d[wr_idx]  = dec_illegal;
        end
    end

    // Flushed pushes are dropped, so they must not be counted either
    always_comb begin
        cnt_d = cnt_q;
        if (push && !flush && dec_illegal && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            cnt_q   <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= 32'd0;
                type_q[i] <= IMM_R;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= inst_d[i];
                type_q[i] <= type_d[i];
                ill_q[i]  <= ill_d[i];
            end
        end
    end

    // Stale slot contents are masked so an empty buffer shows neutral values
    assign out_inst     = out_valid ? inst_q[0] : 32'd0;
    assign out_imm_type = out_valid ? type_q[0] : IMM_R;
    assign out_illegal  = out_valid ? ill_q[0]  : 1'b0;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_stage1_imm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stage1_imm_ctrl
//
// Directed-vector bench for stage1_imm_ctrl.  Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, i.e. after the edge
// has settled.  Each transaction prints one line.
// ----------------------------------------------------------------------------
module tb_stage1_imm_ctrl;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_ISTAR = 3'd2, T_S = 3'd3,
                           T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_type;
    logic        out_illegal;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] illegal_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    stage1_imm_ctrl #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_inst      (in_inst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_inst     (out_inst),
        .out_imm_type (out_imm_type),
        .out_illegal  (out_illegal),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the next rising edge
    task automatic cycle(input string name, input logic iv, input logic [31:0] ii,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_inst   = ii;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        if (name != "")
            $display("txn %-12s in_v=%0b inst=%08h ordy=%0b flush=%0b -> out_v=%0b out=%08h type=%0d ill=%0b in_rdy=%0b cnt=%0d",
                     name, iv, ii, ordy, fl, out_valid, out_inst, out_imm_type,
                     out_illegal, in_ready, illegal_cnt);
    endtask

    task automatic check_head(input string tag, input logic [31:0] inst,
                              input logic [2:0] typ, input logic ill);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".inst"},  out_inst, inst);
        check_eq({tag, ".type"},  {29'd0, out_imm_type}, {29'd0, typ});
        check_eq({tag, ".ill"},   {31'd0, out_illegal}, {31'd0, ill});
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".inst"},  out_inst, 32'd0);
        check_eq({tag, ".type"},  {29'd0, out_imm_type}, {29'd0, T_R});
        check_eq({tag, ".ill"},   {31'd0, out_illegal}, 32'd0);
        check_eq({tag, ".in_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    vec_t dec_tab[10] = '{
        '{32'h00000033, T_R,     1'b0},   // add
        '{32'h00002003, T_I,     1'b0},   // lw
        '{32'h00008067, T_I,     1'b0},   // jalr
        '{32'h00000073, T_I,     1'b0},   // ecall
        '{32'h00105013, T_ISTAR, 1'b0},   // srli
        '{32'h00002013, T_I,     1'b0},   // slti
        '{32'h00112023, T_S,     1'b0},   // sw
        '{32'h00000017, T_U,     1'b0},   // auipc
        '{32'h0000006F, T_J,     1'b0},   // jal
        '{32'h0000007F, T_R,     1'b1}    // unknown opcode
    };

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b0; flush = 1'b0;
        #2;
        check_empty("rst");
        check_eq("rst.cnt", {16'd0, illegal_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single push then pop
        cycle("push_addi", 1'b1, 32'h00500093, 1'b1, 1'b0);
        check_head("addi", 32'h00500093, T_I, 1'b0);
        cycle("pop_addi", 1'b0, 32'h0, 1'b1, 1'b0);
        check_empty("addi_gone");

        // Fill and drain
        cycle("push_slli", 1'b1, 32'h00301013, 1'b0, 1'b0);
        check_head("slli", 32'h00301013, T_ISTAR, 1'b0);
        check_eq("one.in_rdy", {31'd0, in_ready}, 32'd1);
        cycle("push_beq", 1'b1, 32'hFE000EE3, 1'b0, 1'b0);
        check_eq("full.in_rdy", {31'd0, in_ready}, 32'd0);
        check_head("full_hold", 32'h00301013, T_ISTAR, 1'b0);
        cycle("stall", 1'b1, 32'h00000033, 1'b0, 1'b0);
        check_head("stall_hold", 32'h00301013, T_ISTAR, 1'b0);
        cycle("pop_slli", 1'b0, 32'h0, 1'b1, 1'b0);
        check_head("beq", 32'hFE000EE3, T_B, 1'b0);
        check_eq("drain.in_rdy", {31'd0, in_ready}, 32'd1);
        cycle("pop_beq", 1'b0, 32'h0, 1'b1, 1'b0);
        check_empty("drained");

        // FULL with simultaneous push attempt and pop
        cycle("push_addi", 1'b1, 32'h00500093, 1'b0, 1'b0);
        cycle("push_lui", 1'b1, 32'h123450B7, 1'b0, 1'b0);
        check_eq("full2.in_rdy", {31'd0, in_ready}, 32'd0);
        cycle("full_pop", 1'b1, 32'h00112023, 1'b1, 1'b0);
        check_head("lui", 32'h123450B7, T_U, 1'b0);
        check_eq("fp.in_rdy", {31'd0, in_ready}, 32'd1);
        cycle("push_sw", 1'b1, 32'h00112023, 1'b0, 1'b0);
        check_eq("fp.full", {31'd0, in_ready}, 32'd0);
        check_head("lui_hold", 32'h123450B7, T_U, 1'b0);
        cycle("pop_lui", 1'b0, 32'h0, 1'b1, 1'b0);
        check_head("sw", 32'h00112023, T_S, 1'b0);
        cycle("pop_sw", 1'b0, 32'h0, 1'b1, 1'b0);
        check_empty("fp_drained");

        // Flush overrides push and pop; dropped illegal is not counted
        cycle("push_jal", 1'b1, 32'h0000006F, 1'b0, 1'b0);
        check_head("jal", 32'h0000006F, T_J, 1'b0);
        cycle("flush", 1'b1, 32'h00000000, 1'b1, 1'b1);
        check_empty("flushed");
        check_eq("flush.cnt", {16'd0, illegal_cnt}, 32'd0);

        // Illegal counting: back-to-back push+pop in ONE
        for (int k = 0; k < 3; k++) begin
            cycle("push_ill", 1'b1, 32'h00000000, 1'b1, 1'b0);
            exp_cnt++;
            check_head("ill", 32'h00000000, T_R, 1'b1);
            check_eq("ill.cnt", {16'd0, illegal_cnt}, exp_cnt);
        end
        cycle("pop_ill", 1'b0, 32'h0, 1'b1, 1'b0);
        check_empty("ill_drained");

        // Decode table, streamed one per cycle
        foreach (dec_tab[k]) begin
            cycle("decode", 1'b1, dec_tab[k].inst, 1'b1, 1'b0);
            if (dec_tab[k].ill) exp_cnt++;
            check_head("dec", dec_tab[k].inst, dec_tab[k].typ, dec_tab[k].ill);
        end
        check_eq("dec.cnt", {16'd0, illegal_cnt}, exp_cnt);

        // Bring the counter to saturation, then one more illegal push
        in_valid = 1'b1; in_inst = 32'h0; out_ready = 1'b1; flush = 1'b0;
        while (exp_cnt < 16'hFFFF) begin
            @(posedge clk);
            exp_cnt++;
        end
        #1;
        $display("txn %-12s cnt=%0h", "preload", illegal_cnt);
        check_eq("sat.pre", {16'd0, illegal_cnt}, 32'h0000FFFF);
        cycle("push_sat", 1'b1, 32'h00000000, 1'b1, 1'b0);
        check_head("sat", 32'h00000000, T_R, 1'b1);
        check_eq("sat.cnt", {16'd0, illegal_cnt}, 32'h0000FFFF);
        cycle("pop_sat", 1'b0, 32'h0, 1'b1, 1'b0);
        check_empty("sat_drained");

        // Async reset mid-cycle while FULL
        cycle("push_addi", 1'b1, 32'h00500093, 1'b0, 1'b0);
        cycle("push_lui", 1'b1, 32'h123450B7, 1'b0, 1'b0);
        check_eq("pre_rst.in_rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        $display("txn %-12s out_v=%0b in_rdy=%0b cnt=%0d", "async_rst",
                 out_valid, in_ready, illegal_cnt);
        check_empty("arst");
        check_eq("arst.cnt", {16'd0, illegal_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_empty("post_rst");
        cycle("push_post", 1'b1, 32'h00500093, 1'b0, 1'b0);
        check_head("post", 32'h00500093, T_I, 1'b0);
        check_eq("post.in_rdy", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
